// File: rtl/bp_common_pkg.sv
// Shared config-bus definitions: per-core config register map, sequencer entry
// indices and sequencer FSM states.
package bp_common_pkg;

    localparam logic [19:0] cfg_reg_freeze_gp      = 20'h0_0002;
    localparam logic [19:0] cfg_reg_npc_gp         = 20'h0_0003;
    localparam logic [19:0] cfg_reg_hio_mask_gp    = 20'h0_0004;
    localparam logic [19:0] cfg_reg_icache_mode_gp = 20'h0_0022;
    localparam logic [19:0] cfg_reg_dcache_mode_gp = 20'h0_0043;

    // Phase-A write order within one core
    typedef enum logic [2:0] {
        e_cfg_freeze,
        e_cfg_npc,
        e_cfg_hio_mask,
        e_cfg_icache_mode,
        e_cfg_dcache_mode
    } bp_cfg_entry_e;

    typedef enum logic [2:0] {
        e_idle,
        e_send,
        e_read,
        e_wait,
        e_done,
        e_error
    } bp_cfg_state_e;

endpackage

// File: rtl/bp_zynq_cfg_entry_rom.sv
// Maps the current sequencer entry to its config register address and write data.
// Phase B reuses the freeze entry with data 0 to release the core.
module bp_zynq_cfg_entry_rom
    import bp_common_pkg::*;
#(
    parameter int cfg_addr_width_p = 20,
    parameter int cfg_data_width_p = 64,
    parameter int vaddr_width_p    = 39
) (
    input  bp_cfg_entry_e                entry_i,
    input  logic                         phase_b_i,
    input  logic [vaddr_width_p-1:0]     boot_pc_i,
    input  logic [1:0]                   cache_mode_i,
    output logic [cfg_addr_width_p-1:0]  addr_o,
    output logic [cfg_data_width_p-1:0]  data_o
);

    always_comb begin
        addr_o = '0;
        data_o = '0;
        case (entry_i)
            e_cfg_freeze: begin
                addr_o = cfg_addr_width_p'(cfg_reg_freeze_gp);
                data_o = phase_b_i ? '0 : cfg_data_width_p'(1);
            end
            e_cfg_npc: begin
                addr_o = cfg_addr_width_p'(cfg_reg_npc_gp);
                data_o = cfg_data_width_p'(boot_pc_i);
            end
            e_cfg_hio_mask: begin
                addr_o = cfg_addr_width_p'(cfg_reg_hio_mask_gp);
                data_o = cfg_data_width_p'(1);
            end
            e_cfg_icache_mode: begin
                addr_o = cfg_addr_width_p'(cfg_reg_icache_mode_gp);
                data_o = cfg_data_width_p'(cache_mode_i[0]);
            end
            e_cfg_dcache_mode: begin
                addr_o = cfg_addr_width_p'(cfg_reg_dcache_mode_gp);
                data_o = cfg_data_width_p'(cache_mode_i[1]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_zynq_cfg_sequencer.sv
// Boot-time config sequencer: freezes and programs every core, then unfreezes them.
// Define BP_ZYNQ_CFG_READBACK_EN to verify each write with a read-back.
module bp_zynq_cfg_sequencer
    import bp_common_pkg::*;
#(
    parameter int num_core_p       = 1,
    parameter int cfg_addr_width_p = 20,
    parameter int cfg_data_width_p = 64,
    parameter int vaddr_width_p    = 39,
    localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [vaddr_width_p-1:0]     boot_pc_i,
    input  logic [1:0]                   cache_mode_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_and_i,
    output logic                         cfg_w_o,
    output logic [core_width_lp-1:0]     cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    input  logic                         resp_v_i,
    input  logic [cfg_data_width_p-1:0]  resp_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);

    bp_cfg_state_e              state_q, state_d;
    bp_cfg_entry_e              entry_q, entry_d;
    logic [core_width_lp-1:0]   core_q, core_d;
    logic                       phase_b_q, phase_b_d;
    logic [vaddr_width_p-1:0]   boot_pc_q, boot_pc_d;
    logic [1:0]                 cache_mode_q, cache_mode_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    logic [cfg_addr_width_p-1:0] rom_addr;
    logic [cfg_data_width_p-1:0] rom_data;
    logic                        core_last, last_beat, advance;

    bp_zynq_cfg_entry_rom #(
        .cfg_addr_width_p (cfg_addr_width_p),
        .cfg_data_width_p (cfg_data_width_p),
        .vaddr_width_p    (vaddr_width_p)
    ) entry_rom (
        .entry_i      (entry_q),
        .phase_b_i    (phase_b_q),
        .boot_pc_i    (boot_pc_q),
        .cache_mode_i (cache_mode_q),
        .addr_o       (rom_addr),
        .data_o       (rom_data)
    );

    assign core_last = (core_q == core_width_lp'(num_core_p - 1));
    assign last_beat = phase_b_q && core_last;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_idle;
            entry_q      <= e_cfg_freeze;
            core_q       <= '0;
            phase_b_q    <= 1'b0;
            boot_pc_q    <= '0;
            cache_mode_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            core_q       <= core_d;
            phase_b_q    <= phase_b_d;
            boot_pc_q    <= boot_pc_d;
            cache_mode_q <= cache_mode_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        core_d       = core_q;
        phase_b_d    = phase_b_q;
        boot_pc_d    = boot_pc_q;
        cache_mode_d = cache_mode_q;
        done_d       = done_q;
        error_d      = error_q;
        advance      = 1'b0;

        case (state_q)
            e_idle: if (start_i) begin
                boot_pc_d    = boot_pc_i;
                cache_mode_d = cache_mode_i;
                done_d       = 1'b0;
                entry_d      = e_cfg_freeze;
                core_d       = '0;
                phase_b_d    = 1'b0;
                state_d      = e_send;
            end
            e_send: if (cfg_ready_and_i) begin
`ifdef BP_ZYNQ_CFG_READBACK_EN
                state_d = e_read;
`else
                advance = 1'b1;
`endif
            end
            e_read: if (cfg_ready_and_i) state_d = e_wait;
            e_wait: if (resp_v_i) begin
                if (resp_data_i == rom_data) begin
                    advance = 1'b1;
                end else begin
                    error_d = 1'b1;
                    state_d = e_error;
                end
            end
            e_done:  state_d = e_idle;
            e_error: state_d = e_error;
            default: state_d = e_idle;
        endcase

        // Step entry -> core -> phase; the next beat is presented immediately
        if (advance) begin
            if (last_beat) begin
                state_d = e_done;
                done_d  = 1'b1;
            end else begin
                state_d = e_send;
                if (phase_b_q) begin
                    core_d = core_q + 1'b1;
                end else if (entry_q == e_cfg_dcache_mode) begin
                    entry_d = e_cfg_freeze;
                    if (core_last) begin
                        core_d    = '0;
                        phase_b_d = 1'b1;
                    end else begin
                        core_d = core_q + 1'b1;
                    end
                end else begin
                    entry_d = bp_cfg_entry_e'(entry_q + 3'd1);
                end
            end
        end
    end

    always_comb begin
        cfg_v_o = 1'b0;
        busy_o  = 1'b0;
        cfg_w_o = 1'b1;
        case (state_q)
            e_send: begin
                cfg_v_o = 1'b1;
                busy_o  = 1'b1;
            end
            e_read: begin
                cfg_v_o = 1'b1;
                busy_o  = 1'b1;
`ifdef BP_ZYNQ_CFG_READBACK_EN
                cfg_w_o = 1'b0;
`endif
            end
            e_wait:  busy_o = 1'b1;
            default: ;
        endcase
    end

    assign cfg_core_o = core_q;
    assign cfg_addr_o = rom_addr;
    assign cfg_data_o = rom_data;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_bp_zynq_cfg_sequencer.sv
// Randomized bench for bp_zynq_cfg_sequencer: a 1-core and a 4-core instance
// checked against a write-list model built from the sequencing rules.
module tb_bp_zynq_cfg_sequencer;
    import bp_common_pkg::*;

    typedef struct packed {
        logic [3:0]  core;
        logic [19:0] addr;
        logic [63:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic        rst = 1'b1;
    logic [38:0] pc  = '0;
    logic [1:0]  mode = '0;

    logic        start1 = 1'b0, v1, rdy1 = 1'b1, w1, rv1 = 1'b0, busy1, done1, err1;
    logic [0:0]  core1;
    logic [19:0] addr1;
    logic [63:0] data1, rd1 = '0;

    logic        start4 = 1'b0, v4, rdy4 = 1'b1, w4, rv4 = 1'b0, busy4, done4, err4;
    logic [1:0]  core4;
    logic [19:0] addr4;
    logic [63:0] data4, rd4 = '0;

    bp_zynq_cfg_sequencer #(.num_core_p(1)) u1 (
        .clk_i(clk), .reset_i(rst), .start_i(start1), .boot_pc_i(pc), .cache_mode_i(mode),
        .cfg_v_o(v1), .cfg_ready_and_i(rdy1), .cfg_w_o(w1), .cfg_core_o(core1),
        .cfg_addr_o(addr1), .cfg_data_o(data1), .resp_v_i(rv1), .resp_data_i(rd1),
        .busy_o(busy1), .done_o(done1), .error_o(err1));

    bp_zynq_cfg_sequencer #(.num_core_p(4)) u4 (
        .clk_i(clk), .reset_i(rst), .start_i(start4), .boot_pc_i(pc), .cache_mode_i(mode),
        .cfg_v_o(v4), .cfg_ready_and_i(rdy4), .cfg_w_o(w4), .cfg_core_o(core4),
        .cfg_addr_o(addr4), .cfg_data_o(data4), .resp_v_i(rv4), .resp_data_i(rd4),
        .busy_o(busy4), .done_o(done4), .error_o(err4));

    // Observed write streams plus a memory image that answers read-backs
    beat_t       wq1[$], wq4[$];
    int          wcyc1[$];
    logic [63:0] mem1[int], mem4[int];
    int          k1, k4, stall_err4 = 0, w0_4 = 0;
    bit          stall4 = 0, flip = 0, rand_rdy = 0, rsp1_due = 0, rsp4_due = 0;
    logic [86:0] held4;
    logic [63:0] rsp1_data, rsp4_data;
    beat_t       b;

    always @(negedge clk) begin
        if (!rst) begin
            k1 = int'(core1) * (1 << 20) + int'(addr1);
            if (v1 && rdy1) begin
                if (w1) begin
                    b.core = 4'(core1); b.addr = addr1; b.data = data1;
                    wq1.push_back(b); wcyc1.push_back(cyc); mem1[k1] = data1;
                end else begin
                    rsp1_data = mem1[k1]; rsp1_due = 1;
                end
            end
            k4 = int'(core4) * (1 << 20) + int'(addr4);
            if (stall4 && (!v4 || {w4, core4, addr4, data4} !== held4)) stall_err4++;
            if (v4 && !w4) w0_4++;
            if (v4 && rdy4) begin
                if (w4) begin
                    b.core = 4'(core4); b.addr = addr4; b.data = data4;
                    wq4.push_back(b); mem4[k4] = data4;
                end else begin
                    rsp4_data = mem4[k4];
                    if (flip && addr4 == cfg_reg_npc_gp && core4 == 2'd0) rsp4_data[0] = ~rsp4_data[0];
                    rsp4_due = 1;
                end
            end
            stall4 = v4 && !rdy4;
            held4  = {w4, core4, addr4, data4};
        end else begin
            stall4 = 0;
        end
    end

    always @(posedge clk) begin
        #1;
`ifdef BP_ZYNQ_CFG_READBACK_EN
        rv1 = rsp1_due; rd1 = rsp1_data; rsp1_due = 0;
        rv4 = rsp4_due; rd4 = rsp4_data; rsp4_due = 0;
`else
        rv1 = 1'($urandom_range(0, 1)); rd1 = {$urandom, $urandom};
        rv4 = 1'($urandom_range(0, 1)); rd4 = {$urandom, $urandom};
`endif
        rdy4 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Expected write list: five setup writes per core, then freeze=0 per core
    function automatic void build_exp(input int n, input logic [38:0] p, input logic [1:0] m,
                                      output beat_t q[$]);
        beat_t e;
        q.delete();
        for (int c = 0; c < n; c++) begin
            e.core = 4'(c);
            e.addr = cfg_reg_freeze_gp;      e.data = 64'd1;      q.push_back(e);
            e.addr = cfg_reg_npc_gp;         e.data = 64'(p);     q.push_back(e);
            e.addr = cfg_reg_hio_mask_gp;    e.data = 64'd1;      q.push_back(e);
            e.addr = cfg_reg_icache_mode_gp; e.data = 64'(m[0]);  q.push_back(e);
            e.addr = cfg_reg_dcache_mode_gp; e.data = 64'(m[1]);  q.push_back(e);
        end
        for (int c = 0; c < n; c++) begin
            e.core = 4'(c); e.addr = cfg_reg_freeze_gp; e.data = 64'd0; q.push_back(e);
        end
    endfunction

    task automatic pulse1(output int s);
        @(posedge clk); #1; start1 = 1'b1; s = cyc;
        @(posedge clk); #1; start1 = 1'b0;
    endtask

    task automatic pulse4(output int s);
        @(posedge clk); #1; start4 = 1'b1; s = cyc;
        @(posedge clk); #1; start4 = 1'b0;
    endtask

    task automatic wait_end1(input int lim, output bit ok, output int dc);
        ok = 0; dc = -1;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if (done1 || err1) begin ok = 1; dc = cyc; end
        end
    endtask

    task automatic wait_end4(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if (done4 || err4) ok = 1;
        end
    endtask

    task automatic wait_writes4(input int n, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if (wq4.size() >= n) ok = 1;
        end
    endtask

    task automatic cmp_list4(input string nm, input beat_t e[$]);
        checks++;
        if (wq4.size() != e.size()) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", nm, wq4.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < wq4.size(); i++) begin
            checks++;
            if (wq4[i] !== e[i]) begin
                errors++;
                $display("FAIL %s beat %0d: got %h expected %h", nm, i, wq4[i], e[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if ({v1, busy1, done1, err1} !== 4'b0) begin
            errors++; $display("FAIL reset u1 v/busy/done/err: got %b expected 0000", {v1, busy1, done1, err1});
        end
        if ({v4, busy4, done4, err4} !== 4'b0) begin
            errors++; $display("FAIL reset u4 v/busy/done/err: got %b expected 0000", {v4, busy4, done4, err4});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_core;
        beat_t e[$];
        int s, dc;
        bit ok;
        pc = 39'h0_8000_0000; mode = 2'($urandom_range(0, 3));
        build_exp(1, pc, mode, e);
        wq1.delete(); wcyc1.delete();
        pulse1(s);
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL single busy after start: got %b expected 1", busy1); end
        wait_end1(500, ok, dc);
        checks += 4;
        if (!ok)            begin errors++; $display("FAIL single timeout: done not seen"); end
        if (done1 !== 1'b1) begin errors++; $display("FAIL single done: got %b expected 1", done1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL single busy at done: got %b expected 0", busy1); end
        if (wq1.size() != 6) begin errors++; $display("FAIL single count: got %0d expected 6", wq1.size()); end
        for (int i = 0; i < 6 && i < wq1.size(); i++) begin
            checks++;
            if (wq1[i] !== e[i]) begin errors++; $display("FAIL single beat %0d: got %h expected %h", i, wq1[i], e[i]); end
        end
`ifndef BP_ZYNQ_CFG_READBACK_EN
        checks++;
        if (dc != s + 7) begin errors++; $display("FAIL single done latency: got %0d expected 7", dc - s); end
        for (int i = 0; i < wcyc1.size(); i++) begin
            checks++;
            if (wcyc1[i] != s + 1 + i) begin
                errors++; $display("FAIL single beat %0d cycle: got %0d expected %0d", i, wcyc1[i] - s, i + 1);
            end
        end
`endif
        @(negedge clk); #1;
        checks++;
        if (done1 !== 1'b1) begin errors++; $display("FAIL single done sticky: got %b expected 1", done1); end
    endtask

    task automatic test_multi_core_stalls;
        beat_t e[$];
        int s;
        bit ok;
        pc = {$urandom, $urandom}; mode = 2'($urandom_range(0, 3));
        build_exp(4, pc, mode, e);
        wq4.delete(); stall_err4 = 0; rand_rdy = 1;
        pulse4(s);
        wait_end4(3000, ok);
        rand_rdy = 0;
        checks += 4;
        if (!ok)              begin errors++; $display("FAIL multi timeout: done not seen"); end
        if (done4 !== 1'b1)   begin errors++; $display("FAIL multi done: got %b expected 1", done4); end
        if (err4 !== 1'b0)    begin errors++; $display("FAIL multi error: got %b expected 0", err4); end
        if (stall_err4 != 0)  begin errors++; $display("FAIL multi stall stability: got %0d changes expected 0", stall_err4); end
        cmp_list4("multi", e);
    endtask

    task automatic test_reset_mid;
        beat_t e[$];
        int s;
        bit ok;
        pc = {$urandom, $urandom}; mode = 2'($urandom_range(0, 3));
        build_exp(4, pc, mode, e);
        wq4.delete();
        pulse4(s);
        wait_writes4(3, 500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset timeout: 3 writes not seen"); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({v4, busy4, done4, err4} !== 4'b0) begin
            errors++; $display("FAIL midreset v/busy/done/err: got %b expected 0000", {v4, busy4, done4, err4});
        end
        rst = 1'b0;
        wq4.delete();
        pulse4(s);
        wait_end4(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset restart timeout"); end
        cmp_list4("midreset", e);
    endtask

    task automatic test_start_ignored;
        beat_t e[$];
        int s;
        bit ok;
        pc = {$urandom, $urandom}; mode = 2'($urandom_range(0, 3));
        build_exp(4, pc, mode, e);
        wq4.delete(); rand_rdy = 1;
        pulse4(s);
        wait_writes4(7, 1000, ok);
        pc = ~pc; mode = ~mode;
        pulse4(s);
        wait_end4(3000, ok);
        rand_rdy = 0;
        checks += 2;
        if (!ok)            begin errors++; $display("FAIL ignored timeout: done not seen"); end
        if (done4 !== 1'b1) begin errors++; $display("FAIL ignored done: got %b expected 1", done4); end
        cmp_list4("ignored", e);
    endtask

`ifdef BP_ZYNQ_CFG_READBACK_EN
    task automatic test_readback_error;
        int s, vcnt;
        bit ok;
        pc = {$urandom, $urandom} | 39'h1; mode = 2'($urandom_range(0, 3));
        wq4.delete(); flip = 1;
        pulse4(s);
        wait_end4(500, ok);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v4) vcnt++;
        end
        flip = 0;
        checks += 5;
        if (!ok)            begin errors++; $display("FAIL rberr timeout: error not seen"); end
        if (err4 !== 1'b1)  begin errors++; $display("FAIL rberr error: got %b expected 1", err4); end
        if (done4 !== 1'b0) begin errors++; $display("FAIL rberr done: got %b expected 0", done4); end
        if (vcnt != 0)      begin errors++; $display("FAIL rberr cfg_v after error: got %0d expected 0", vcnt); end
        if (wq4.size() != 2) begin errors++; $display("FAIL rberr writes: got %0d expected 2", wq4.size()); end
    endtask
`else
    task automatic test_resp_ignored;
        beat_t e[$];
        int s;
        bit ok;
        pc = {$urandom, $urandom}; mode = 2'($urandom_range(0, 3));
        build_exp(4, pc, mode, e);
        wq4.delete(); w0_4 = 0;
        pulse4(s);
        wait_end4(500, ok);
        checks += 4;
        if (!ok)            begin errors++; $display("FAIL respign timeout: done not seen"); end
        if (w0_4 != 0)      begin errors++; $display("FAIL respign cfg_w low: got %0d cycles expected 0", w0_4); end
        if (err4 !== 1'b0)  begin errors++; $display("FAIL respign error: got %b expected 0", err4); end
        if (done4 !== 1'b1) begin errors++; $display("FAIL respign done: got %b expected 1", done4); end
        cmp_list4("respign", e);
    endtask
`endif

    initial begin
        test_reset;
        test_single_core;
        test_multi_core_stalls;
        test_reset_mid;
        test_start_ignored;
`ifdef BP_ZYNQ_CFG_READBACK_EN
        test_readback_error;
`else
        test_resp_ignored;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
